// File: rtl/dnn_arb_pkg.sv
// Shared types and helpers for the two-master SDRAM arbiter.
package dnn_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Master identifier: 0 = accelerator, 1 = CPU.
    typedef logic mid_t;

    localparam mid_t M_ACCEL = 1'b0;
    localparam mid_t M_CPU   = 1'b1;

    // Round-robin pick: on contention the master not granted last wins.
    function automatic mid_t rr_pick(input logic req0, input logic req1, input mid_t last);
        mid_t win;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = M_CPU;
        end else begin
            win = M_ACCEL;
        end
        return win;
    endfunction

endpackage

// File: rtl/dnn_arb_id_fifo.sv
// Register-based FIFO of master IDs for reads awaiting their response.
// A push into a full FIFO is honoured only when a pop happens in the
// same cycle, so the occupancy holds instead of overflowing.
module dnn_arb_id_fifo
    import dnn_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  mid_t                     din_i,
    output mid_t                     dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    mid_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Popping an empty FIFO is ignored, which drops stray responses.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= M_ACCEL;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/dnn_mem_arbiter.sv
// Two-master Avalon-MM arbiter (m0 = accelerator, m1 = CPU) in front of one
// SDRAM controller. One command is in flight at a time; read responses are
// routed back by an in-order ID FIFO. Optional per-master accepted-transfer
// counters are built when DNN_ARB_PERF_EN is defined.
module dnn_mem_arbiter
    import dnn_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // accelerator port
    input  logic [ADDR_W-1:0]           m0_address_i,
    input  logic                        m0_read_i,
    input  logic                        m0_write_i,
    input  logic [DATA_W-1:0]           m0_writedata_i,
    input  logic [DATA_W/8-1:0]         m0_byteenable_i,
    output logic                        m0_waitrequest_o,
    output logic [DATA_W-1:0]           m0_readdata_o,
    output logic                        m0_readdatavalid_o,
    // CPU port
    input  logic [ADDR_W-1:0]           m1_address_i,
    input  logic                        m1_read_i,
    input  logic                        m1_write_i,
    input  logic [DATA_W-1:0]           m1_writedata_i,
    input  logic [DATA_W/8-1:0]         m1_byteenable_i,
    output logic                        m1_waitrequest_o,
    output logic [DATA_W-1:0]           m1_readdata_o,
    output logic                        m1_readdatavalid_o,
    // SDRAM controller port
    output logic [ADDR_W-1:0]           s_address_o,
    output logic                        s_read_o,
    output logic                        s_write_o,
    output logic [DATA_W-1:0]           s_writedata_o,
    output logic [DATA_W/8-1:0]         s_byteenable_o,
    input  logic                        s_waitrequest_i,
    input  logic [DATA_W-1:0]           s_readdata_i,
    input  logic                        s_readdatavalid_i,
`ifdef DNN_ARB_PERF_EN
    input  logic                        perf_clr_i,
    output logic [31:0]                 perf_gnt0_o,
    output logic [31:0]                 perf_gnt1_o,
`endif
    // observability
    output arb_state_t                  dbg_state_o,
    output logic [$clog2(MAX_PEND):0]   dbg_pend_o
);

    // Handshake: a command moves on every edge where read or write is high
    // and waitrequest is low; readdatavalid marks a one-cycle response.

    arb_state_t state_q, state_d;
    mid_t       gnt_q, gnt_d;
    mid_t       last_gnt_q, last_gnt_d;

    logic       fifo_full, fifo_empty, fifo_push;
    mid_t       fifo_head;
    logic       req0, req1;
    logic       sel_read, sel_write;
    logic       rsp_valid;

    // A read may only be granted if its ID has a FIFO slot; writes never wait on it.
    assign req0 = m0_write_i || (m0_read_i && !fifo_full);
    assign req1 = m1_write_i || (m1_read_i && !fifo_full);

    assign sel_read  = (gnt_q == M_CPU) ? m1_read_i  : m0_read_i;
    assign sel_write = (gnt_q == M_CPU) ? m1_write_i : m0_write_i;

    // Payload follows the held grant; it is only meaningful while BUSY.
    assign s_address_o    = (gnt_q == M_CPU) ? m1_address_i    : m0_address_i;
    assign s_writedata_o  = (gnt_q == M_CPU) ? m1_writedata_i  : m0_writedata_i;
    assign s_byteenable_o = (gnt_q == M_CPU) ? m1_byteenable_i : m0_byteenable_i;

    // Next-state, grant and command/waitrequest steering.
    always_comb begin
        state_d          = state_q;
        gnt_d            = gnt_q;
        last_gnt_d       = last_gnt_q;
        s_read_o         = 1'b0;
        s_write_o        = 1'b0;
        m0_waitrequest_o = 1'b1;
        m1_waitrequest_o = 1'b1;
        fifo_push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = rr_pick(req0, req1, last_gnt_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_read_o  = sel_read;
                s_write_o = sel_write;
                if (gnt_q == M_CPU) begin
                    m1_waitrequest_o = s_waitrequest_i;
                end else begin
                    m0_waitrequest_o = s_waitrequest_i;
                end
                // The grant is held until the slave accepts, even if the
                // master drops its command meanwhile.
                if (!s_waitrequest_i) begin
                    state_d    = IDLE;
                    last_gnt_d = gnt_q;
                    fifo_push  = sel_read;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, grant and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= M_ACCEL;
            last_gnt_q <= M_CPU;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    dnn_arb_id_fifo #(
        .DEPTH (MAX_PEND)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (s_readdatavalid_i),
        .din_i   (gnt_q),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (dbg_pend_o)
    );

    // Responses with nothing outstanding are dropped.
    assign rsp_valid          = s_readdatavalid_i && !fifo_empty;
    assign m0_readdatavalid_o = rsp_valid && (fifo_head == M_ACCEL);
    assign m1_readdatavalid_o = rsp_valid && (fifo_head == M_CPU);
    assign m0_readdata_o      = s_readdata_i;
    assign m1_readdata_o      = s_readdata_i;

    assign dbg_state_o = state_q;

`ifdef DNN_ARB_PERF_EN
    logic [31:0] perf_gnt0_q, perf_gnt1_q;
    logic        xfer_done;

    assign xfer_done   = (state_q == BUSY) && !s_waitrequest_i;
    assign perf_gnt0_o = perf_gnt0_q;
    assign perf_gnt1_o = perf_gnt1_q;

    // Accepted-transfer counters; clear wins over increment, wrap at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0_q <= '0;
            perf_gnt1_q <= '0;
        end else if (perf_clr_i) begin
            perf_gnt0_q <= '0;
            perf_gnt1_q <= '0;
        end else if (xfer_done) begin
            if (gnt_q == M_CPU) begin
                perf_gnt1_q <= perf_gnt1_q + 32'd1;
            end else begin
                perf_gnt0_q <= perf_gnt0_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// Self-checking bench for dnn_mem_arbiter: a cycle vector table, directed
// multi-cycle sequences and a randomized phase checked by a
// transaction-level reference model (in-order read ID queue).
module tb_dnn_mem_arbiter;
    import dnn_arb_pkg::*;

    localparam int MAX_PEND = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        m_rd, m_wr;
    logic [31:0]       m_addr  [2];
    logic [31:0]       m_wdata [2];
    logic [3:0]        m_be    [2];
    logic [1:0]        m_wait, m_rdv;
    logic [31:0]       m_rdata [2];
    logic [31:0]       s_addr, s_wdata, s_rdata;
    logic [3:0]        s_be;
    logic              s_rd, s_wr, s_wait, s_rdv;
    arb_state_t        dbg_state;
    logic [2:0]        dbg_pend;

    int n_chk  = 0;
    int n_fail = 0;

    dnn_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_PEND(MAX_PEND)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .m0_address_i       (m_addr[0]),
        .m0_read_i          (m_rd[0]),
        .m0_write_i         (m_wr[0]),
        .m0_writedata_i     (m_wdata[0]),
        .m0_byteenable_i    (m_be[0]),
        .m0_waitrequest_o   (m_wait[0]),
        .m0_readdata_o      (m_rdata[0]),
        .m0_readdatavalid_o (m_rdv[0]),
        .m1_address_i       (m_addr[1]),
        .m1_read_i          (m_rd[1]),
        .m1_write_i         (m_wr[1]),
        .m1_writedata_i     (m_wdata[1]),
        .m1_byteenable_i    (m_be[1]),
        .m1_waitrequest_o   (m_wait[1]),
        .m1_readdata_o      (m_rdata[1]),
        .m1_readdatavalid_o (m_rdv[1]),
        .s_address_o        (s_addr),
        .s_read_o           (s_rd),
        .s_write_o          (s_wr),
        .s_writedata_o      (s_wdata),
        .s_byteenable_o     (s_be),
        .s_waitrequest_i    (s_wait),
        .s_readdata_i       (s_rdata),
        .s_readdatavalid_i  (s_rdv),
        .dbg_state_o        (dbg_state),
        .dbg_pend_o         (dbg_pend)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        m_rd = 2'b00; m_wr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = 4'hF;
        end
        s_wait = 1'b0; s_rdv = 1'b0; s_rdata = '0;
    endtask

    // Ends at posedge+1 with reset released and the DUT idle.
    task automatic do_reset();
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Presents one command on master m and holds it until accepted.
    task automatic issue(input int m, input bit is_rd, input logic [31:0] addr,
                         input logic [31:0] data);
        bit ok = 1'b0;
        m_rd[m] = is_rd; m_wr[m] = !is_rd;
        m_addr[m] = addr; m_wdata[m] = data; m_be[m] = 4'hF;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (m_wait[m] == 1'b0) ok = 1'b1;
            @(posedge clk); #1;
        end
        m_rd[m] = 1'b0; m_wr[m] = 1'b0;
        check($sformatf("issue_accepted_m%0d", m), 64'(ok), 64'd1);
    endtask

    // Drives one read response and checks its routing.
    task automatic respond(input logic [31:0] data, input int exp_m);
        s_rdv = 1'b1; s_rdata = data;
        @(negedge clk);
        check("rsp_route", 64'(m_rdv), (exp_m == 0) ? 64'd1 : 64'd2);
        check("rsp_data", 64'(m_rdata[exp_m]), 64'(data));
        @(posedge clk); #1;
        s_rdv = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit   rst;
        logic m0_rd, m0_wr, m1_rd, m1_wr, sw;
        logic e_srd, e_swr, e_w0, e_w1;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [14];

    // ---------------- scoreboard state ----------------
    logic [0:0]  exp_q [$];
    logic        act_c [2];
    logic        rd_c  [2];
    logic [31:0] addr_c[2], data_c[2];
    logic [3:0]  be_c  [2];
    int          wait_c[2];

    initial begin
        int acc_cnt, acc_m, last_acc, max_wait;
        logic [0:0] id;
        bit found, bad;

        rst_n = 1'b0;
        clear_inputs();

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_read", 64'(s_rd), 64'd0);
        check("rst_s_write", 64'(s_wr), 64'd0);
        check("rst_waitreq", 64'(m_wait), 64'd3);
        check("rst_rdv", 64'(m_rdv), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        check("rst_pend", 64'(dbg_pend), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single read with 3 stall cycles, then two writers held continuously.
        //            rst m0r m0w m1r m1w sw   srd swr w0 w1 addr
        vecs[0]  = '{1, 1, 0, 0, 0, 1,   0, 0, 1, 1, 32'h0};
        vecs[1]  = '{0, 1, 0, 0, 0, 1,   1, 0, 1, 1, 32'h100};
        vecs[2]  = '{0, 1, 0, 0, 0, 1,   1, 0, 1, 1, 32'h100};
        vecs[3]  = '{0, 1, 0, 0, 0, 1,   1, 0, 1, 1, 32'h100};
        vecs[4]  = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 32'h100};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 32'h0};
        vecs[6]  = '{1, 0, 1, 0, 1, 0,   0, 0, 1, 1, 32'h0};
        vecs[7]  = '{0, 0, 1, 0, 1, 0,   0, 1, 0, 1, 32'h100};
        vecs[8]  = '{0, 0, 1, 0, 1, 0,   0, 0, 1, 1, 32'h0};
        vecs[9]  = '{0, 0, 1, 0, 1, 0,   0, 1, 1, 0, 32'h200};
        vecs[10] = '{0, 0, 1, 0, 1, 0,   0, 0, 1, 1, 32'h0};
        vecs[11] = '{0, 0, 1, 0, 1, 0,   0, 1, 0, 1, 32'h100};
        vecs[12] = '{0, 0, 1, 0, 1, 0,   0, 0, 1, 1, 32'h0};
        vecs[13] = '{0, 0, 1, 0, 1, 0,   0, 1, 1, 0, 32'h200};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            m_addr[0] = 32'h100; m_addr[1] = 32'h200;
            m_rd = {vecs[i].m1_rd, vecs[i].m0_rd};
            m_wr = {vecs[i].m1_wr, vecs[i].m0_wr};
            s_wait = vecs[i].sw;
            @(negedge clk);
            check($sformatf("vec%0d_s_read", i), 64'(s_rd), 64'(vecs[i].e_srd));
            check($sformatf("vec%0d_s_write", i), 64'(s_wr), 64'(vecs[i].e_swr));
            check($sformatf("vec%0d_m0_wait", i), 64'(m_wait[0]), 64'(vecs[i].e_w0));
            check($sformatf("vec%0d_m1_wait", i), 64'(m_wait[1]), 64'(vecs[i].e_w1));
            if (vecs[i].e_srd || vecs[i].e_swr)
                check($sformatf("vec%0d_s_addr", i), 64'(s_addr), 64'(vecs[i].e_addr));
            @(posedge clk); #1;
        end

        // Responses route back to their own master, in order.
        do_reset();
        issue(0, 1'b1, 32'hA00, 32'h0);
        issue(1, 1'b1, 32'hB00, 32'h0);
        respond(32'hAAAA, 0);
        respond(32'hBBBB, 1);

        // Fill the ID FIFO, then a 5th read must wait while a write passes.
        do_reset();
        issue(0, 1'b1, 32'h10, 32'h0);
        issue(1, 1'b1, 32'h20, 32'h0);
        issue(0, 1'b1, 32'h30, 32'h0);
        issue(1, 1'b1, 32'h40, 32'h0);
        check("pend_full", 64'(dbg_pend), 64'd4);
        m_rd[0] = 1'b1; m_addr[0] = 32'h50;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_wait[0] !== 1'b1 || s_rd !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        check("full_blocks_read", 64'(bad), 64'd0);
        issue(1, 1'b0, 32'h60, 32'hCAFE);
        check("pend_after_write", 64'(dbg_pend), 64'd4);

        // Free one slot; the waiting read then completes alongside another response.
        respond(32'h1111, 0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (m_wait[0] == 1'b0) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("m0_regrant", 64'(found), 64'd1);
        if (found) begin
            check("pend_before_pushpop", 64'(dbg_pend), 64'd3);
            s_rdv = 1'b1; s_rdata = 32'h2222;
            #1;
            check("pushpop_route", 64'(m_rdv), 64'd2);
            check("pushpop_data", 64'(m_rdata[1]), 64'h2222);
            @(posedge clk); #1;
            s_rdv = 1'b0; m_rd[0] = 1'b0;
            check("pend_after_pushpop", 64'(dbg_pend), 64'd3);
        end else begin
            m_rd[0] = 1'b0;
        end
        respond(32'h3000, 0);
        respond(32'h3001, 1);
        respond(32'h3002, 0);
        check("pend_drained", 64'(dbg_pend), 64'd0);
        // Stray response with nothing outstanding.
        s_rdv = 1'b1; s_rdata = 32'hDEAD;
        @(negedge clk);
        check("stray_rsp_dropped", 64'(m_rdv), 64'd0);
        @(posedge clk); #1;
        s_rdv = 1'b0;
        check("pend_no_underflow", 64'(dbg_pend), 64'd0);

        // Reset while BUSY with two reads outstanding.
        do_reset();
        issue(0, 1'b1, 32'h70, 32'h0);
        issue(1, 1'b1, 32'h80, 32'h0);
        s_wait = 1'b1; m_rd[0] = 1'b1; m_addr[0] = 32'h90;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (s_rd == 1'b1) found = 1'b1;
        end
        check("busy_reached", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstbusy_s_read", 64'(s_rd), 64'd0);
        check("rstbusy_pend", 64'(dbg_pend), 64'd0);
        check("rstbusy_wait", 64'(m_wait), 64'd3);
        m_rd = 2'b00; s_wait = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rdv = 1'b1; s_rdata = 32'hBEEF;
        @(negedge clk);
        check("late_rsp_dropped", 64'(m_rdv), 64'd0);
        @(posedge clk); #1;
        s_rdv = 1'b0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        exp_q.delete();
        for (int m = 0; m < 2; m++) begin act_c[m] = 1'b0; wait_c[m] = 0; end
        last_acc = -10; max_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_wait = ($urandom_range(0, 3) == 0);
            if (exp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                s_rdv = 1'b1; s_rdata = $urandom;
            end else begin
                s_rdv = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (!act_c[m] && $urandom_range(0, 1) == 1) begin
                    act_c[m]  = 1'b1;
                    rd_c[m]   = $urandom_range(0, 1);
                    addr_c[m] = {m[0], 31'($urandom)};
                    data_c[m] = $urandom;
                    be_c[m]   = rd_c[m] ? 4'hF : 4'($urandom);
                    wait_c[m] = 0;
                end
                m_rd[m] = act_c[m] && rd_c[m];
                m_wr[m] = act_c[m] && !rd_c[m];
                m_addr[m] = addr_c[m]; m_wdata[m] = data_c[m]; m_be[m] = be_c[m];
            end

            @(negedge clk);
            if (s_rdv) begin
                id = exp_q.pop_front();
                check("rnd_rsp_route", 64'(m_rdv), (id == 1'b0) ? 64'd1 : 64'd2);
                check("rnd_rsp_data", 64'(m_rdata[id]), 64'(s_rdata));
            end else begin
                check("rnd_no_rsp", 64'(m_rdv), 64'd0);
            end
            acc_cnt = 0; acc_m = 0;
            for (int m = 0; m < 2; m++) begin
                if (act_c[m] && m_wait[m] == 1'b0) begin acc_cnt++; acc_m = m; end
            end
            check("rnd_accept_agrees", 64'((s_rd || s_wr) && !s_wait), 64'(acc_cnt == 1));
            if (acc_cnt == 1) begin
                check("rnd_s_read", 64'(s_rd), 64'(rd_c[acc_m]));
                check("rnd_s_write", 64'(s_wr), 64'(!rd_c[acc_m]));
                check("rnd_s_addr", 64'(s_addr), 64'(addr_c[acc_m]));
                check("rnd_s_be", 64'(s_be), 64'(be_c[acc_m]));
                if (!rd_c[acc_m]) check("rnd_s_wdata", 64'(s_wdata), 64'(data_c[acc_m]));
                check("rnd_gap", 64'(cyc - last_acc >= 2), 64'd1);
                last_acc = cyc;
                if (rd_c[acc_m]) begin
                    exp_q.push_back(acc_m[0]);
                    check("rnd_pend_bound", 64'(exp_q.size() <= MAX_PEND), 64'd1);
                end
            end
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (act_c[m]) begin
                    if (acc_cnt == 1 && acc_m == m) act_c[m] = 1'b0;
                    else wait_c[m]++;
                    if (wait_c[m] > max_wait) max_wait = wait_c[m];
                end
            end
        end
        s_rdv = 1'b0; m_rd = 2'b00; m_wr = 2'b00;
        check("rnd_no_starvation", 64'(max_wait < 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
